// File: rtl/avr_pkg.sv
// Shared AVR core definitions.
// Fetch state encoding and opcode classes.
package avr_pkg;

  typedef enum logic [1:0] {
    FETCH1,
    FETCH2,
    HOLD,
    SKIP
  } fetch_state_t;

  localparam logic [15:0] JMP_MASK = 16'hFE0C;
  localparam logic [15:0] JMP_VAL  = 16'h940C;
  localparam logic [15:0] LDS_MASK = 16'hFC0F;
  localparam logic [15:0] LDS_VAL  = 16'h9000;
  localparam logic [15:0] NOP      = 16'h0000;

  function automatic logic is_two_word(
    input logic [15:0] w
  );
    return ((w & JMP_MASK) == JMP_VAL) ||
           ((w & LDS_MASK) == LDS_VAL);
  endfunction

endpackage

// File: rtl/avr_two_word_det.sv
// Two-word opcode detector.
// Flags JMP/CALL and LDS/STS first words.
module avr_two_word_det
  import avr_pkg::*;
(
  input  logic [15:0] op,
  output logic        two
);

  // pure decode of the opcode word
  always_comb begin
    two = is_two_word(op);
  end

endmodule

// File: rtl/avr_fetch_ctrl.sv
// AVR instruction-fetch sequencer.
// Owns the PC, assembles 1/2-word instrs.
module avr_fetch_ctrl
  import avr_pkg::*;
#(
  parameter int PC_WIDTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] rom_addr,
  input  logic [15:0]         rom_data,
  output logic [PC_WIDTH-1:0] pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [15:0]         instr,
  output logic [15:0]         instr_op2,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_two,
  input  logic                branch_req,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                skip_req
);

  localparam logic [PC_WIDTH-1:0] ONE = PC_WIDTH'(1);
  localparam logic [PC_WIDTH-1:0] TWO = PC_WIDTH'(2);

  fetch_state_t state;
  logic         two;
  logic         xfer;

  avr_two_word_det u_det (
    .op  (rom_data),
    .two (two)
  );

  assign rom_addr = pc;
  assign xfer     = instr_valid & instr_ready;

  // fetch sequencer: PC, instruction regs, handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH1;
      pc          <= RESET_VECTOR;
      instr_valid <= 1'b0;
      instr       <= NOP;
      instr_op2   <= NOP;
      instr_pc    <= RESET_VECTOR;
      instr_two   <= 1'b0;
    end else begin
      unique case (state)
        FETCH1: begin
          instr     <= rom_data;
          instr_pc  <= pc;
          instr_op2 <= NOP;
          pc        <= pc + ONE;
          if (two) begin
            instr_two <= 1'b1;
            state     <= FETCH2;
          end else begin
            instr_two   <= 1'b0;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        FETCH2: begin
          instr_op2   <= rom_data;
          pc          <= pc + ONE;
          instr_valid <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (xfer) begin
            instr_valid <= 1'b0;
            if (branch_req) begin
              pc    <= branch_target;
              state <= FETCH1;
            end else if (skip_req) begin
              state <= SKIP;
            end else begin
              state <= FETCH1;
            end
          end
        end
        SKIP: begin
          pc    <= pc + (two ? TWO : ONE);
          state <= FETCH1;
        end
        default: state <= FETCH1;
      endcase
    end
  end

endmodule
